// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: RV32M/RV64M multiply/divide unit with fixed-latency multiply and iterative restoring divide.
module execute_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_BITS    = 1,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 requestValid,
  output logic                 requestReady,
  input  logic [2:0]           requestOp,
  input  logic [TAG_WIDTH-1:0] requestTag,
  input  logic [XLEN-1:0]      operand1,
  input  logic [XLEN-1:0]      operand2,
  input  logic                 flush,
  output logic                 responseValid,
  input  logic                 responseReady,
  output logic [XLEN-1:0]      responseResult,
  output logic [TAG_WIDTH-1:0] responseTag,
  output logic                 busy
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  localparam logic [6:0] MUL_LAST = 7'(MUL_LATENCY - 2);
  localparam logic [6:0] DIV_LAST = 7'(XLEN / DIV_BITS - 1);
  state_t                r_state;
  logic [1:0]            r_op;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [6:0]            r_cnt;
  logic [2*XLEN-1:0]     r_ma, r_mb;
  logic [XLEN-1:0]       r_quo, r_rem, r_div, r_result;
  logic                  r_neg_q, r_neg_r;
  logic                  w_accept, w_neg1, w_neg2, w_dz, w_ov, w_ge;
  logic [1:0]            w_mop;
  logic [2*XLEN-1:0]     w_ma, w_mb, w_prod;
  logic [XLEN-1:0]       w_mres, w_abs1, w_abs2, w_spec, w_quo_n, w_rem_n, w_q, w_r;
  logic [XLEN:0]         w_t;
  function automatic logic [2*XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic s);
    return {{XLEN{s & v[XLEN-1]}}, v};
  endfunction
  assign requestReady   = reset && r_state == S_IDLE;
  assign busy           = r_state != S_IDLE;
  assign responseValid  = r_state == S_DONE;
  assign responseResult = r_result;
  assign responseTag    = r_tag;
  assign w_accept       = requestValid && requestReady && !flush;
  // In IDLE the multiplier sees the request directly so MUL_LATENCY=1 can finish at accept
  always_comb begin
    w_ma   = r_state == S_IDLE ? ext(operand1, requestOp[1:0] == 2'd1 || requestOp[1:0] == 2'd2) : r_ma;
    w_mb   = r_state == S_IDLE ? ext(operand2, requestOp[1:0] == 2'd1) : r_mb;
    w_mop  = r_state == S_IDLE ? requestOp[1:0] : r_op;
    w_prod = w_ma * w_mb;
    w_mres = w_mop == 2'd0 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    w_neg1 = !requestOp[0] && operand1[XLEN-1];
    w_neg2 = !requestOp[0] && operand2[XLEN-1];
    w_abs1 = w_neg1 ? -operand1 : operand1;
    w_abs2 = w_neg2 ? -operand2 : operand2;
    w_dz   = operand2 == '0;
    w_ov   = !requestOp[0] && operand1 == {1'b1, {(XLEN-1){1'b0}}} && &operand2;
    w_spec = w_dz ? (requestOp[1] ? operand1 : '1) : (requestOp[1] ? '0 : operand1);
    w_q    = r_neg_q ? -r_quo : r_quo;
    w_r    = r_neg_r ? -r_rem : r_rem;
  end
  // Restoring step: DIV_BITS dividend bits shift into the partial remainder per cycle
  always_comb begin
    w_rem_n = r_rem;
    w_quo_n = r_quo;
    w_t     = '0;
    w_ge    = 1'b0;
    for (int k = 0; k < DIV_BITS; k++) begin
      w_t        = {w_rem_n, w_quo_n[XLEN-1]};
      w_ge       = w_t >= {1'b0, r_div};
      w_rem_n    = w_ge ? XLEN'(w_t - {1'b0, r_div}) : w_t[XLEN-1:0];
      w_quo_n    = {w_quo_n[XLEN-2:0], w_ge};
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_tag    <= '0;
      r_cnt    <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= requestOp[1:0];
          r_tag   <= requestTag;
          r_cnt   <= '0;
          r_ma    <= w_ma;
          r_mb    <= w_mb;
          r_quo   <= w_abs1;
          r_rem   <= '0;
          r_div   <= w_abs2;
          r_neg_q <= w_neg1 ^ w_neg2;
          r_neg_r <= w_neg1;
          if (!requestOp[2]) begin
            r_result <= w_mres;
            if (MUL_LATENCY == 1) r_state <= S_DONE;
            else r_state <= S_MUL;
          end else if (w_dz || w_ov) begin
            r_result <= w_spec;
            r_state  <= S_DONE;
          end else r_state <= S_DIV;
        end
        S_MUL: begin
          r_cnt <= r_cnt + 7'd1;
          if (r_cnt == MUL_LAST) begin
            r_result <= w_mres;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          r_cnt <= r_cnt + 7'd1;
          if (r_cnt == DIV_LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= r_op[1] ? w_r : w_q;
          r_state  <= S_DONE;
        end
        S_DONE: if (responseReady) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: directed and model-checked tests of a 32-bit and a 64-bit muldiv unit.
module tb_execute_muldiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  logic        a_req_valid = 0, a_req_ready, a_flush = 0, a_resp_valid, a_resp_ready = 0, a_busy;
  logic [2:0]  a_op = 0;
  logic [4:0]  a_tag_in = 0, a_tag_out;
  logic [31:0] a_x = 0, a_y = 0, a_res;
  logic        b_req_valid = 0, b_req_ready, b_resp_valid, b_resp_ready = 0, b_busy;
  logic [2:0]  b_op = 0;
  logic [4:0]  b_tag_in = 0, b_tag_out;
  logic [63:0] b_x = 0, b_y = 0, b_res;
  int total = 0;
  int bad = 0;
  execute_muldiv_unit dut_a (
    .clock(clock), .reset(reset), .requestValid(a_req_valid), .requestReady(a_req_ready),
    .requestOp(a_op), .requestTag(a_tag_in), .operand1(a_x), .operand2(a_y), .flush(a_flush),
    .responseValid(a_resp_valid), .responseReady(a_resp_ready), .responseResult(a_res),
    .responseTag(a_tag_out), .busy(a_busy)
  );
  execute_muldiv_unit #(.XLEN(64), .MUL_LATENCY(1), .DIV_BITS(4)) dut_b (
    .clock(clock), .reset(reset), .requestValid(b_req_valid), .requestReady(b_req_ready),
    .requestOp(b_op), .requestTag(b_tag_in), .operand1(b_x), .operand2(b_y), .flush(1'b0),
    .responseValid(b_resp_valid), .responseReady(b_resp_ready), .responseResult(b_res),
    .responseTag(b_tag_out), .busy(b_busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sr;
    logic [63:0] ua, ub, ur;
    logic ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ov = a == 32'h80000000 && b == 32'hFFFFFFFF;
    case (op)
      3'd0: begin ur = ua * ub; return ur[31:0]; end
      3'd1: begin sr = sa * sb; return sr[63:32]; end
      3'd2: begin sr = sa * $signed(ub); return sr[63:32]; end
      3'd3: begin ur = ua * ub; return ur[63:32]; end
      3'd4: begin sr = sa / sb; return b == 0 ? 32'hFFFFFFFF : ov ? a : sr[31:0]; end
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: begin sr = sa % sb; return b == 0 ? a : ov ? 32'h0 : sr[31:0]; end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int lat32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 34;
  endfunction
  task automatic a_issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] tg);
    int n = 0;
    while (!a_req_ready && n < 100) begin @(posedge clock); #1; n++; end
    a_op = op; a_x = x; a_y = y; a_tag_in = tg; a_req_valid = 1;
    @(posedge clock); #1;
    a_req_valid = 0;
  endtask
  task automatic a_wait(output int lat);
    lat = 1;
    while (!a_resp_valid && lat < 100) begin @(posedge clock); #1; lat++; end
  endtask
  task automatic a_take();
    a_resp_ready = 1;
    @(posedge clock); #1;
    a_resp_ready = 0;
  endtask
  task automatic a_do(input string nm, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] tg, input logic [31:0] exp, input int explat);
    int lat;
    a_issue(op, x, y, tg);
    a_wait(lat);
    check({nm, "_res"}, a_res, exp);
    check({nm, "_tag"}, a_tag_out, tg);
    check({nm, "_lat"}, lat, explat);
    a_take();
  endtask
  task automatic b_do(input string nm, input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                      input logic [4:0] tg, input logic [63:0] exp, input int explat);
    int n = 0;
    int lat = 1;
    while (!b_req_ready && n < 100) begin @(posedge clock); #1; n++; end
    b_op = op; b_x = x; b_y = y; b_tag_in = tg; b_req_valid = 1;
    @(posedge clock); #1;
    b_req_valid = 0;
    while (!b_resp_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    check({nm, "_res"}, b_res, exp);
    check({nm, "_tag"}, b_tag_out, tg);
    check({nm, "_lat"}, lat, explat);
    b_resp_ready = 1;
    @(posedge clock); #1;
    b_resp_ready = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int lat;
    logic seen;
    logic [2:0] op;
    logic [31:0] x, y;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", a_req_ready, 0);
    check("rst_valid", a_resp_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_res", a_res, 0);
    check("rst_tag", a_tag_out, 0);
    reset = 1;
    @(posedge clock); #1;
    check("idle_ready", a_req_ready, 1);
    a_do("mulh", 3'd1, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 2);
    a_do("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF, 2);
    a_do("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 2);
    a_do("mul", 3'd0, 32'd7, 32'd6, 5'd4, 32'd42, 2);
    a_do("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd21, 32'hFFFFFFFD, 34);
    a_do("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd22, 32'hFFFFFFFF, 34);
    a_do("divu", 3'd5, 32'd100, 32'd7, 5'd23, 32'd14, 34);
    a_do("remu", 3'd7, 32'd100, 32'd7, 5'd24, 32'd2, 34);
    a_do("divu_z", 3'd5, 32'd5, 32'd0, 5'd25, 32'hFFFFFFFF, 1);
    a_do("remu_z", 3'd7, 32'd5, 32'd0, 5'd26, 32'd5, 1);
    a_do("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd27, 32'h80000000, 1);
    a_do("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd28, 32'd0, 1);
    a_issue(3'd0, 32'd7, 32'd6, 5'd9);
    a_wait(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", a_resp_valid, 1);
      check("bp_res", a_res, 42);
      check("bp_tag", a_tag_out, 9);
      check("bp_ready", a_req_ready, 0);
      @(posedge clock); #1;
    end
    a_take();
    check("bp_ready_after", a_req_ready, 1);
    a_issue(3'd5, 32'd100, 32'd7, 5'd10);
    check("bp_accept", a_busy, 1);
    a_wait(lat);
    check("bp_next_res", a_res, 14);
    check("bp_next_lat", lat, 34);
    a_take();
    a_issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd3);
    repeat (9) begin @(posedge clock); #1; end
    a_flush = 1;
    @(posedge clock); #1;
    a_flush = 0;
    check("fl_busy", a_busy, 0);
    check("fl_valid", a_resp_valid, 0);
    check("fl_ready", a_req_ready, 1);
    seen = 0;
    repeat (40) begin
      if (a_resp_valid) seen = 1;
      @(posedge clock); #1;
    end
    check("fl_noresp", seen, 0);
    a_do("fl_mul", 3'd0, 32'd7, 32'd6, 5'd11, 32'd42, 2);
    a_issue(3'd0, 32'd3, 32'd5, 5'd12);
    a_wait(lat);
    a_flush = 1; a_resp_ready = 1;
    @(posedge clock); #1;
    a_flush = 0; a_resp_ready = 0;
    check("fld_valid", a_resp_valid, 0);
    check("fld_busy", a_busy, 0);
    a_flush = 1; a_op = 3'd0; a_req_valid = 1;
    @(posedge clock); #1;
    a_flush = 0; a_req_valid = 0;
    check("fl_noaccept", a_busy, 0);
    a_issue(3'd5, 32'd100, 32'd7, 5'd7);
    repeat (5) begin @(posedge clock); #1; end
    reset = 0;
    @(posedge clock); #1;
    check("mr_valid", a_resp_valid, 0);
    check("mr_res", a_res, 0);
    check("mr_tag", a_tag_out, 0);
    check("mr_busy", a_busy, 0);
    check("mr_ready", a_req_ready, 0);
    reset = 1;
    @(posedge clock); #1;
    a_do("mr_remu", 3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 34);
    b_do("b_div", 3'd4, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd1, 64'hFFFFFFFFFFFFFFFD, 18);
    b_do("b_rem", 3'd6, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd2, 64'hFFFFFFFFFFFFFFFF, 18);
    b_do("b_divu", 3'd5, 64'd100, 64'd7, 5'd3, 64'd14, 18);
    b_do("b_remu", 3'd7, 64'd100, 64'd7, 5'd4, 64'd2, 18);
    b_do("b_divu_big", 3'd5, 64'h123456789ABCDEF0, 64'h10, 5'd5, 64'h0123456789ABCDEF, 18);
    b_do("b_divu_z", 3'd5, 64'd5, 64'd0, 5'd6, 64'hFFFFFFFFFFFFFFFF, 1);
    b_do("b_div_ov", 3'd4, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd7, 64'h8000000000000000, 1);
    b_do("b_rem_ov", 3'd6, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd8, 64'd0, 1);
    b_do("b_mul", 3'd0, 64'd7, 64'd6, 5'd9, 64'd42, 1);
    b_do("b_mulhu", 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd10, 64'hFFFFFFFFFFFFFFFE, 1);
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 20));
        default: ;
      endcase
      a_do("rand", op, x, y, 5'(i), ref32(op, x, y), lat32(op, x, y));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
